mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : mem_arbiter_if                                          |
// | Purpose  : Requester and memory-side signal bundle for the          |
// |            two-port (fetch/data) single-memory arbiter.             |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   // Instruction-fetch port
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_done;
   logic [DATA_W-1:0] i_rdata;
   // Data-access port
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_done;
   logic [DATA_W-1:0] d_rdata;
   // Memory side
   logic [ADDR_W-1:0] addra;
   logic [DATA_W-1:0] DataWrite;
   logic              MemWrite;
   logic [DATA_W-1:0] DataOut;
   // Status
   logic              busy;

   // Arbiter view
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, DataOut,
      output i_done, i_rdata, d_done, d_rdata, addra, DataWrite, MemWrite, busy
   );

   // Requester / memory-model view
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, DataOut,
      input  i_done, i_rdata, d_done, d_rdata, addra, DataWrite, MemWrite, busy
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : mem_arbiter                                             |
// | Purpose  : Shares one synchronous memory between an instruction     |
// |            fetch port and a data port. Data wins by default; a      |
// |            2-bit starvation counter hands the slot to the fetch     |
// |            after two consecutive losses. One access per 3 cycles.   |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   localparam logic [1:0] c_STARVE_MAX = 2'd2;

   state_t            r_state;
   state_t            w_stateNext;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_iRdata;
   logic [DATA_W-1:0] r_dRdata;
   logic              r_memWrite;
   logic              r_iDone;
   logic              r_dDone;
   logic              r_ownerData;
   logic              r_isWrite;
   logic [1:0]        r_starve;
   logic              w_iElig;
   logic              w_dElig;
   logic              w_grantI;
   logic              w_grantD;

   // A requester whose done is high this cycle is still holding req for the
   // access that just finished, so it is masked to prevent a double grant.
   assign w_iElig = bus.i_req & ~r_iDone;
   assign w_dElig = bus.d_req & ~r_dDone;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state and grant decision; grants are only made from IDLE
   always_comb begin
      w_stateNext = r_state;
      w_grantI    = 1'b0;
      w_grantD    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_dElig && !(w_iElig && (r_starve == c_STARVE_MAX))) begin
               w_grantD = 1'b1;
            end else if (w_iElig) begin
               w_grantI = 1'b1;
            end
            if (w_grantD || w_grantI) begin
               w_stateNext = ISSUE;
            end
         end
         ISSUE:   w_stateNext = CAPTURE;
         CAPTURE: w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   // Access registers: latch winner operands, strobe write in ISSUE, capture read data and pulse done
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_memWrite  <= 1'b0;
         r_isWrite   <= 1'b0;
         r_ownerData <= 1'b0;
         r_iDone     <= 1'b0;
         r_dDone     <= 1'b0;
         r_iRdata    <= '0;
         r_dRdata    <= '0;
      end else begin
         r_memWrite <= 1'b0;
         r_iDone    <= 1'b0;
         r_dDone    <= 1'b0;
         if (w_grantD) begin
            r_addr      <= bus.d_addr;
            r_wdata     <= bus.d_wdata;
            r_memWrite  <= bus.d_we;
            r_isWrite   <= bus.d_we;
            r_ownerData <= 1'b1;
         end else if (w_grantI) begin
            r_addr      <= bus.i_addr;
            r_wdata     <= '0;
            r_isWrite   <= 1'b0;
            r_ownerData <= 1'b0;
         end
         if (r_state == CAPTURE) begin
            if (r_ownerData) begin
               r_dDone <= 1'b1;
               if (!r_isWrite) begin
                  r_dRdata <= bus.DataOut;
               end
            end else begin
               r_iDone  <= 1'b1;
               r_iRdata <= bus.DataOut;
            end
         end
      end
   end

   // Fetch starvation counter, updated only where a grant decision is taken
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_starve <= '0;
      end else if (r_state == IDLE) begin
         if (w_grantI || !bus.i_req) begin
            r_starve <= '0;
         end else if (w_grantD && w_iElig && (r_starve != c_STARVE_MAX)) begin
            r_starve <= r_starve + 2'd1;
         end
      end
   end

   assign bus.addra     = r_addr;
   assign bus.DataWrite = r_wdata;
   assign bus.MemWrite  = r_memWrite;
   assign bus.i_done    = r_iDone;
   assign bus.i_rdata   = r_iRdata;
   assign bus.d_done    = r_dDone;
   assign bus.d_rdata   = r_dRdata;
   assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module   : tb_mem_arbiter                                          |
// | Purpose  : Self-checking bench for mem_arbiter with a synchronous   |
// |            256-word memory model and a shadow reference memory.     |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_mem_arbiter;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   vecs  = 0;
   int   errs  = 0;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Synchronous memory: write on MemWrite, read data one cycle after addra
   logic [DATA_W-1:0] memArr [0:255];
   logic [DATA_W-1:0] shadow [0:255];
   always @(posedge clk) begin
      if (bus.MemWrite) memArr[bus.addra[7:0]] <= bus.DataWrite;
      bus.DataOut <= memArr[bus.addra[7:0]];
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // Drive one access from a single requester and observe it until done
   task automatic runAccess(input bit isData, input bit we, input logic [15:0] addr,
                            input logic [15:0] wdata, output logic [15:0] rdata,
                            output int lat, output int wrCycles, output logic [15:0] wrAddr,
                            output bit timedOut, output bit afterHigh);
      rdata = '0; lat = 0; wrCycles = 0; wrAddr = '0; timedOut = 1'b1;
      if (isData) begin
         bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_req = 1'b1;
      end else begin
         bus.i_addr = addr; bus.i_req = 1'b1;
      end
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         lat++;
         if (bus.MemWrite) begin
            wrCycles++;
            wrAddr = bus.addra;
         end
         if (isData ? bus.d_done : bus.i_done) begin
            timedOut = 1'b0;
            rdata = isData ? bus.d_rdata : bus.i_rdata;
            break;
         end
      end
      bus.d_req = 1'b0;
      bus.i_req = 1'b0;
      @(posedge clk); #1;
      afterHigh = isData ? bus.d_done : bus.i_done;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vecs++; if (bus.addra !== 16'h0) begin errs++; $display("FAIL reset_addra: got %h required %h", bus.addra, 16'h0); end
      vecs++; if (bus.DataWrite !== 16'h0) begin errs++; $display("FAIL reset_datawrite: got %h required %h", bus.DataWrite, 16'h0); end
      vecs++; if ({bus.MemWrite, bus.i_done, bus.d_done, bus.busy} !== 4'b0) begin errs++;
         $display("FAIL reset_strobes: got %b required %b", {bus.MemWrite, bus.i_done, bus.d_done, bus.busy}, 4'b0); end
      vecs++; if ({bus.i_rdata, bus.d_rdata} !== 32'h0) begin errs++;
         $display("FAIL reset_rdata: got %h required %h", {bus.i_rdata, bus.d_rdata}, 32'h0); end
      reset = 1'b0;
   endtask

   task automatic test_data_write();
      logic [15:0] rd, wa; int lat, wc; bit to, ah;
      runAccess(1'b1, 1'b1, 16'h0004, 16'h0190, rd, lat, wc, wa, to, ah);
      shadow[4] = 16'h0190;
      vecs++; if (to !== 1'b0 || lat != 3) begin errs++; $display("FAIL write_latency: got %0d (timeout %0d) required 3", lat, to); end
      vecs++; if (wc != 1) begin errs++; $display("FAIL write_strobe_cycles: got %0d required 1", wc); end
      vecs++; if (wa !== 16'h0004) begin errs++; $display("FAIL write_addra: got %h required %h", wa, 16'h0004); end
      vecs++; if (ah !== 1'b0) begin errs++; $display("FAIL write_done_width: got done=%b one cycle later required 0", ah); end
   endtask

   task automatic test_read_back();
      logic [15:0] rd, wa; int lat, wc; bit to, ah;
      runAccess(1'b1, 1'b0, 16'h0004, 16'h0, rd, lat, wc, wa, to, ah);
      vecs++; if (to || rd !== 16'h0190) begin errs++; $display("FAIL readback_4: got %h required %h", rd, 16'h0190); end
      vecs++; if (wc != 0) begin errs++; $display("FAIL readback_no_write: got %0d strobes required 0", wc); end
      for (int i = 0; i <= 10; i++) begin
         runAccess(1'b1, 1'b1, 16'(2 * i), 16'(i * 100), rd, lat, wc, wa, to, ah);
         shadow[2 * i] = 16'(i * 100);
      end
      for (int i = 0; i <= 10; i++) begin
         runAccess(1'b1, 1'b0, 16'(2 * i), 16'h0, rd, lat, wc, wa, to, ah);
         vecs++; if (to || rd !== 16'(i * 100)) begin errs++;
            $display("FAIL readback_table[%0d]: got %h required %h", i, rd, 16'(i * 100)); end
      end
   endtask

   task automatic test_fetch();
      logic [15:0] rd, wa; int lat, wc; bit to, ah;
      runAccess(1'b1, 1'b1, 16'h0010, 16'h1234, rd, lat, wc, wa, to, ah);
      shadow[16] = 16'h1234;
      runAccess(1'b0, 1'b0, 16'h0010, 16'h0, rd, lat, wc, wa, to, ah);
      vecs++; if (to || lat != 3) begin errs++; $display("FAIL fetch_latency: got %0d (timeout %0d) required 3", lat, to); end
      vecs++; if (rd !== 16'h1234) begin errs++; $display("FAIL fetch_rdata: got %h required %h", rd, 16'h1234); end
      vecs++; if (wc != 0) begin errs++; $display("FAIL fetch_memwrite: got %0d strobes required 0", wc); end
      vecs++; if (bus.i_rdata !== 16'h1234) begin errs++; $display("FAIL fetch_rdata_hold: got %h required %h", bus.i_rdata, 16'h1234); end
   endtask

   task automatic test_random();
      logic [15:0] rd, wa, a, w; int lat, wc, op; bit to, ah;
      for (int n = 0; n < 30; n++) begin
         op = int'($urandom_range(0, 2));
         a  = 16'($urandom_range(0, 255));
         w  = 16'($urandom);
         if (op == 0) begin
            runAccess(1'b1, 1'b1, a, w, rd, lat, wc, wa, to, ah);
            shadow[a[7:0]] = w;
            vecs++; if (to || lat != 3 || wc != 1 || wa !== a) begin errs++;
               $display("FAIL rand_write[%0d]: got lat=%0d strobes=%0d addr=%h required lat=3 strobes=1 addr=%h", n, lat, wc, wa, a); end
         end else begin
            runAccess(op == 1, 1'b0, a, 16'h0, rd, lat, wc, wa, to, ah);
            vecs++; if (to || lat != 3 || wc != 0 || rd !== shadow[a[7:0]]) begin errs++;
               $display("FAIL rand_read[%0d] port=%0d: got lat=%0d strobes=%0d data=%h required lat=3 strobes=0 data=%h",
                        n, op, lat, wc, rd, shadow[a[7:0]]); end
         end
      end
   endtask

   // Both requesters held: expected order derived slot by slot from the priority rules
   task automatic test_contention();
      int expSeq [6];
      int gotSeq [$];
      int starve, last, waitCnt, maxWait;
      bit dOk, iOk;
      starve = 0; last = 0;
      for (int k = 0; k < 6; k++) begin
         dOk = (last != 1);
         iOk = (last != 2);
         if (dOk && !(iOk && starve == 2)) begin
            expSeq[k] = 1;
            if (iOk) starve = (starve < 2) ? starve + 1 : 2;
         end else begin
            expSeq[k] = 2;
            starve = 0;
         end
         last = expSeq[k];
      end
      bus.d_we = 1'b0; bus.d_addr = 16'h0030; bus.i_addr = 16'h0031;
      bus.d_req = 1'b1; bus.i_req = 1'b1;
      waitCnt = 0; maxWait = 0;
      for (int e = 0; e < 60 && gotSeq.size() < 6; e++) begin
         @(posedge clk); #1;
         waitCnt++;
         if (bus.d_done) gotSeq.push_back(1);
         if (bus.i_done) begin
            gotSeq.push_back(2);
            if (waitCnt > maxWait) maxWait = waitCnt;
            waitCnt = 0;
         end
      end
      bus.d_req = 1'b0; bus.i_req = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      vecs++; if (gotSeq.size() != 6) begin errs++; $display("FAIL contention_count: got %0d dones required 6", gotSeq.size()); end
      for (int k = 0; k < 6; k++) begin
         if (k < gotSeq.size()) begin
            vecs++; if (gotSeq[k] != expSeq[k]) begin errs++;
               $display("FAIL contention_order[%0d]: got %0d required %0d (1=D 2=I)", k, gotSeq[k], expSeq[k]); end
         end
      end
      vecs++; if (maxWait > 9 || maxWait == 0) begin errs++; $display("FAIL contention_fetch_wait: got %0d cycles required 1..9", maxWait); end
   endtask

   task automatic test_back_to_back();
      int dCnt; bit found;
      bus.d_we = 1'b0; bus.d_addr = 16'h0004; bus.d_req = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.i_addr = 16'h0010; bus.i_req = 1'b1;
      @(posedge clk); #1;
      vecs++; if (bus.d_done !== 1'b1 || bus.d_rdata !== shadow[4]) begin errs++;
         $display("FAIL b2b_data_done: got done=%b data=%h required done=1 data=%h", bus.d_done, bus.d_rdata, shadow[4]); end
      @(posedge clk); #1;
      vecs++; if (bus.busy !== 1'b1 || bus.addra !== 16'h0010) begin errs++;
         $display("FAIL b2b_fetch_grant: got busy=%b addra=%h required busy=1 addra=%h", bus.busy, bus.addra, 16'h0010); end
      bus.d_req = 1'b0;
      dCnt = 0; found = 1'b0;
      for (int e = 0; e < 6 && !found; e++) begin
         @(posedge clk); #1;
         if (bus.d_done) dCnt++;
         if (bus.i_done) found = 1'b1;
      end
      vecs++; if (!found || bus.i_rdata !== shadow[16]) begin errs++;
         $display("FAIL b2b_fetch_done: got found=%b data=%h required found=1 data=%h", found, bus.i_rdata, shadow[16]); end
      vecs++; if (dCnt != 0) begin errs++; $display("FAIL b2b_no_regrant: got %0d extra data dones required 0", dCnt); end
      bus.i_req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort();
      logic [15:0] rd, wa; int lat, wc, dCnt; bit to, ah;
      bus.d_we = 1'b1; bus.d_addr = 16'h0006; bus.d_wdata = 16'hBEEF; bus.d_req = 1'b1;
      @(posedge clk); #1;
      vecs++; if (bus.MemWrite !== 1'b1 || bus.addra !== 16'h0006) begin errs++;
         $display("FAIL abort_issue: got MemWrite=%b addra=%h required 1 and %h", bus.MemWrite, bus.addra, 16'h0006); end
      #2 reset = 1'b1;
      #1;
      vecs++; if ({bus.MemWrite, bus.busy, bus.i_done, bus.d_done} !== 4'b0) begin errs++;
         $display("FAIL abort_strobes: got %b required %b", {bus.MemWrite, bus.busy, bus.i_done, bus.d_done}, 4'b0); end
      vecs++; if ({bus.addra, bus.DataWrite, bus.i_rdata, bus.d_rdata} !== 64'h0) begin errs++;
         $display("FAIL abort_regs: got %h required %h", {bus.addra, bus.DataWrite, bus.i_rdata, bus.d_rdata}, 64'h0); end
      bus.d_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      dCnt = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus.d_done) dCnt++;
      end
      vecs++; if (dCnt != 0) begin errs++; $display("FAIL abort_no_done: got %0d dones required 0", dCnt); end
      runAccess(1'b1, 1'b0, 16'h0006, 16'h0, rd, lat, wc, wa, to, ah);
      vecs++; if (to || lat != 3 || rd !== shadow[6]) begin errs++;
         $display("FAIL abort_recover: got lat=%0d data=%h required lat=3 data=%h", lat, rd, shadow[6]); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         memArr[i] = 16'(i * 37 + 5);
         shadow[i] = 16'(i * 37 + 5);
      end
      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      test_reset();
      test_data_write();
      test_read_back();
      test_fetch();
      test_random();
      test_contention();
      test_back_to_back();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
`default_nettype wire
